// File: rtl/pipe_stall_kill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_kill_ctrl
// Purpose  : Frontend stall/kill controller: DP resource back-pressure and
//            branch-mispredict recovery (kill, PC redirect, wait for ROB squash).
//            Optional macro PIPE_CTRL_PERF_EN adds stall/flush perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_kill_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dp_valid_i,
    input  logic              dp_dst_en_i,
    input  logic              rrf_allocatable_i,
    input  logic              req_alu_i,
    input  logic              req_mem_i,
    input  logic              alu_rs_full_i,
    input  logic              mem_rs_full_i,
    input  logic              rob_full_i,
    input  logic              br_valid_i,
    input  logic              br_mispredict_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              rob_recover_done_i,
    output logic              stall_IF_o,
    output logic              stall_ID_o,
    output logic              stall_DP_o,
    output logic              kill_IF_o,
    output logic              kill_ID_o,
    output logic              kill_DP_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              recover_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles_o,
    output logic [31:0]       perf_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_KILL     = 2'd1,
        S_WAIT_ROB = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_WAIT_MAX = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic                timeout_q, timeout_d;
    logic                res_stall;
    logic                mispredict;
    logic                flush_start;
    logic                run_stall;

    assign res_stall = dp_valid_i &
                       ((dp_dst_en_i & ~rrf_allocatable_i) |
                        (req_alu_i   & alu_rs_full_i)      |
                        (req_mem_i   & mem_rs_full_i)      |
                        rob_full_i);

    assign mispredict = br_valid_i & br_mispredict_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_RUN;
            cnt_q         <= '0;
            redirect_pc_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_pc_d    = redirect_pc_q;
        timeout_d        = timeout_q;
        stall_IF_o       = 1'b0;
        stall_ID_o       = 1'b0;
        stall_DP_o       = 1'b0;
        kill_IF_o        = 1'b0;
        kill_ID_o        = 1'b0;
        kill_DP_o        = 1'b0;
        redirect_valid_o = 1'b0;
        flush_start      = 1'b0;
        run_stall        = 1'b0;

        case (state_q)
            S_RUN: begin
                // Stall outputs follow this cycle's inputs even when a mispredict wins the transition.
                run_stall  = res_stall;
                stall_IF_o = res_stall;
                stall_ID_o = res_stall;
                stall_DP_o = res_stall;
                if (mispredict) begin
                    state_d       = S_KILL;
                    redirect_pc_d = br_target_i;
                    flush_start   = 1'b1;
                end
            end

            S_KILL: begin
                kill_IF_o        = 1'b1;
                kill_ID_o        = 1'b1;
                kill_DP_o        = 1'b1;
                redirect_valid_o = 1'b1;
                cnt_d            = '0;
                state_d          = S_WAIT_ROB;
            end

            S_WAIT_ROB: begin
                // Fetch/decode run ahead from the redirect target; only dispatch is held.
                stall_DP_o = 1'b1;
                if (cnt_q != C_WAIT_MAX) begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
                if (rob_recover_done_i) begin
                    state_d = S_RUN;
                end else if (cnt_q == C_WAIT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_RUN;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign redirect_pc_o     = redirect_pc_q;
    assign recover_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (run_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_start) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles_o = perf_stall_q;
    assign perf_flush_cnt_o    = perf_flush_q;
`else
    logic unused_perf;
    assign unused_perf = run_stall ^ flush_start;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stall_kill_ctrl.md
Name: pipe_stall_kill_ctrl

Overview:
- Central controller that drives the frontend stall/kill lines (IF, ID, DP); these are currently tied to 0 in the core top.
- Raises dispatch back-pressure whenever the instruction in DP needs a resource that is unavailable: RRF entry, ALU/LDST reservation-station slot, or ROB slot.
- On a resolved branch mispredict it runs a recovery sequence: kills the frontend, issues a PC redirect to IFUnit, and holds dispatch until the ROB reports that younger entries are squashed.

Parameters:
- ADDR_W, 32, width of PC/redirect address (matches ADDR_LEN).
- WAIT_MAX, 16, maximum cycles spent in WAIT_ROB before the watchdog fires.
- CNT_W, 5, width of the WAIT_ROB cycle counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- dp_valid_i  in  1  DP stage holds a valid instruction.
- dp_dst_en_i  in  1  DP instruction writes a register and needs an RRF entry.
- rrf_allocatable_i  in  1  RRF can allocate an entry this cycle.
- req_alu_i  in  1  DP instruction targets the ALU RS.
- req_mem_i  in  1  DP instruction targets the LDST RS.
- alu_rs_full_i  in  1  ALU RS has no free slot.
- mem_rs_full_i  in  1  LDST RS has no free slot.
- rob_full_i  in  1  ROB has no free slot.
- br_valid_i  in  1  branch unit result valid this cycle.
- br_mispredict_i  in  1  resolved branch was mispredicted (qualified by br_valid_i).
- br_target_i  in  ADDR_W  correct next PC for the mispredicted branch.
- rob_recover_done_i  in  1  ROB has squashed every entry younger than the branch.
- stall_IF_o, stall_ID_o, stall_DP_o  out  1 each  stage stall.
- kill_IF_o, kill_ID_o, kill_DP_o  out  1 each  stage kill.
- redirect_valid_o  out  1  one-cycle PC redirect strobe to IFUnit.
- redirect_pc_o  out  ADDR_W  redirect target.
- recover_timeout_o  out  1  sticky watchdog flag.

Behaviour:
- States: RUN, KILL, WAIT_ROB. Reset puts the block in RUN.
- Reset values: counter 0, redirect_pc_o 0, recover_timeout_o 0. All stall/kill/redirect outputs evaluate to 0 in RUN when dp_valid_i=0.
- Resource stall is combinational and evaluated only in RUN:
  - res_stall = dp_valid_i & ((dp_dst_en_i & ~rrf_allocatable_i) | (req_alu_i & alu_rs_full_i) | (req_mem_i & mem_rs_full_i) | rob_full_i).
  - stall_IF_o = stall_ID_o = stall_DP_o = res_stall. Kills are 0.
- RUN -> KILL: taken when br_valid_i & br_mispredict_i at an edge. br_target_i is latched into redirect_pc_o at that same edge. The mispredict has priority over res_stall in that cycle; res_stall outputs still reflect the current-cycle inputs.
- KILL (exactly 1 cycle):
  - kill_IF_o = kill_ID_o = kill_DP_o = 1, redirect_valid_o = 1, all stalls 0.
  - Always goes to WAIT_ROB; counter cleared to 0.
- WAIT_ROB:
  - stall_DP_o = 1. stall_IF_o and stall_ID_o = 0, so fetch refills from redirect_pc_o. Kills 0, redirect_valid_o 0.
  - Counter increments each cycle, saturating at WAIT_MAX.
  - rob_recover_done_i = 1 -> RUN at the next edge. stall_DP_o remains 1 during that cycle.
  - Otherwise, counter == WAIT_MAX -> set recover_timeout_o and go to RUN.
  - If rob_recover_done_i and timeout coincide, done wins and the flag is not set.
- Mispredicts arriving in KILL or WAIT_ROB are ignored. redirect_pc_o is not overwritten; only one recovery is in flight at a time.
- redirect_pc_o holds its value until the next accepted mispredict.
- recover_timeout_o clears only on reset.
- reset_i asserted in any state, including mid-recovery: the next cycle is RUN with all outputs at reset values.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds 32-bit outputs perf_stall_cycles_o (increments on every cycle with res_stall=1 in RUN) and perf_flush_cnt_o (increments on each RUN->KILL). Both wrap modulo 2^32, reset to 0.
- Undefined: these ports and counters do not exist, and the other ports behave identically.

Test Plan:
- Reset mid-WAIT_ROB: reset_i=1 for 1 cycle -> next cycle all outputs 0, state RUN, redirect_pc_o=0.
- RRF full:
  - Inputs: dp_valid_i=1, dp_dst_en_i=1, rrf_allocatable_i=0 -> all three stalls=1 in the same cycle.
  - Then rrf_allocatable_i=1 -> stalls=0.
  - With dp_dst_en_i=0, stalls stay 0.
- Mispredict at cycle T with br_target_i=0x0000_0100:
  - T+1: kills=1, redirect_valid_o=1, redirect_pc_o=0x100.
  - T+2: stall_DP_o=1 only.
  - rob_recover_done_i=1 at T+4 -> RUN at T+5.
- Watchdog: rob_recover_done_i held 0 -> after WAIT_MAX=16 cycles in WAIT_ROB, recover_timeout_o=1 and it stays 1 after return to RUN.
- Second mispredict (target 0x200) during WAIT_ROB -> ignored, redirect_pc_o stays 0x100, no extra KILL cycle.
- Simultaneous mispredict and rob_full_i=1 in RUN -> stalls=1 that cycle, KILL next cycle with stalls 0.
